// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator bank: command opcodes and sweep FSM states.
package acc_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } acc_state_e;

endpackage

// File: rtl/acc_alu.sv
// Combinational LOAD/ADD/SUB datapath for one bank entry, with optional saturation.
module acc_alu
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] entry,
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum;
  logic           borrow;

  always_comb begin
    sum    = {1'b0, entry} + {1'b0, operand};
    borrow = operand > entry;
    result = entry;
    carry  = 1'b0;
    case (op)
      OP_LOAD: result = operand;
      OP_ADD: begin
        carry  = sum[WIDTH];
        result = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        carry  = borrow;
        result = (SATURATE && borrow) ? '0 : entry - operand;
      end
      default: result = entry;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/acc_bank.sv
// Accumulator register bank: in-place LOAD/ADD/SUB, dual combinational read ports,
// and a one-entry-per-cycle clear sweep that blocks commands while it runs.
module acc_bank
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter bit          SATURATE = 1'b0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             clr_req,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             carry_o,
  output logic             zero_o,
  output logic             busy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  acc_state_e       state_q, state_d;
  logic [AW-1:0]    sweep_q;
  logic             carry_q, zero_q;

  logic             cmd_in_range, rd_a_in_range, rd_b_in_range;
  logic             sweep_last, do_write;
  logic [WIDTH-1:0] cur_entry, alu_result;
  logic             alu_carry, alu_zero;

  // Only meaningful when DEPTH is not a power of two; otherwise always true.
  assign cmd_in_range  = {1'b0, cmd_addr}  < (AW+1)'(DEPTH);
  assign rd_a_in_range = {1'b0, rd_addr_a} < (AW+1)'(DEPTH);
  assign rd_b_in_range = {1'b0, rd_addr_b} < (AW+1)'(DEPTH);

  assign cur_entry  = cmd_in_range ? mem_q[cmd_addr] : '0;
  assign sweep_last = (sweep_q == AW'(DEPTH - 1));

  acc_alu #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_alu (
    .entry  (cur_entry),
    .operand(cmd_data),
    .op     (cmd_op),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (clr_req) state_d = ST_CLEAR;
      ST_CLEAR: if (sweep_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) && !clr_req;
  assign busy      = (state_q == ST_CLEAR);
  assign do_write  = cmd_valid && cmd_ready && (cmd_op != OP_NOP) && cmd_in_range;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      state_q <= ST_IDLE;
      sweep_q <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        mem_q[sweep_q] <= '0;
        sweep_q        <= sweep_last ? '0 : sweep_q + 1'b1;
        if (sweep_last) begin
          carry_q <= 1'b0;
          zero_q  <= 1'b1;
        end
      end else if (do_write) begin
        mem_q[cmd_addr] <= alu_result;
        carry_q         <= alu_carry;
        zero_q          <= alu_zero;
      end
    end
  end

  // No write-to-read bypass: reads always see the registered array.
  assign rd_data_a = rd_a_in_range ? mem_q[rd_addr_a] : '0;
  assign rd_data_b = rd_b_in_range ? mem_q[rd_addr_b] : '0;
  assign carry_o   = carry_q;
  assign zero_o    = zero_q;

endmodule

// File: tb/tb_acc_bank.sv
// Drives three bank instances (wrap/4, saturate/4, wrap/5) and checks them against a
// scoreboard of expected entry and flag values.
module tb_acc_bank;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      cmd_valid_v;
  logic [1:0]      cmd_op;
  logic [2:0]      cmd_addr;
  logic [7:0]      cmd_data;
  logic            clr_req, clr_req5;
  logic [2:0]      rd_addr_a, rd_addr_b;
  logic [2:0][7:0] rda, rdb;
  logic [2:0]      ready_v, carry_v, zero_v, busy_v;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         d;
    logic [2:0] addr;
    logic [7:0] val;
    logic       c;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [3][8];
  logic       c_m [3];
  logic       z_m [3];
  int         dep [3]   = '{4, 4, 5};
  bit         sat_m [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  acc_bank #(.WIDTH(8), .DEPTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v[0]), .cmd_ready(ready_v[0]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr[1:0]), .cmd_data(cmd_data), .clr_req(clr_req),
    .rd_addr_a(rd_addr_a[1:0]), .rd_data_a(rda[0]), .rd_addr_b(rd_addr_b[1:0]),
    .rd_data_b(rdb[0]), .carry_o(carry_v[0]), .zero_o(zero_v[0]), .busy(busy_v[0])
  );

  acc_bank #(.WIDTH(8), .DEPTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v[1]), .cmd_ready(ready_v[1]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr[1:0]), .cmd_data(cmd_data), .clr_req(clr_req),
    .rd_addr_a(rd_addr_a[1:0]), .rd_data_a(rda[1]), .rd_addr_b(rd_addr_b[1:0]),
    .rd_data_b(rdb[1]), .carry_o(carry_v[1]), .zero_o(zero_v[1]), .busy(busy_v[1])
  );

  acc_bank #(.WIDTH(8), .DEPTH(5), .SATURATE(1'b0)) u_d5 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_v[2]), .cmd_ready(ready_v[2]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .clr_req(clr_req5),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]), .rd_addr_b(rd_addr_b),
    .rd_data_b(rdb[2]), .carry_o(carry_v[2]), .zero_o(zero_v[2]), .busy(busy_v[2])
  );

  task automatic model_reset(input logic [2:0] mask);
    for (int d = 0; d < 3; d++) begin
      if (mask[d]) begin
        for (int a = 0; a < 8; a++) mem_m[d][a] = 8'h00;
        c_m[d] = 1'b0;
        z_m[d] = 1'b1;
      end
    end
  endtask

  // Reference behaviour of one command; pushes the expected post-edge view per instance.
  task automatic model_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data,
                           input string name, input logic [2:0] mask);
    for (int d = 0; d < 3; d++) begin
      logic [2:0] a;
      logic [8:0] s;
      logic [7:0] v;
      exp_t       e;
      if (!mask[d]) continue;
      a = (d == 2) ? addr : {1'b0, addr[1:0]};
      if (int'(a) < dep[d] && op != 2'b00) begin
        case (op)
          2'b01: begin v = data; c_m[d] = 1'b0; end
          2'b10: begin
            s = {1'b0, mem_m[d][a]} + {1'b0, data};
            c_m[d] = s[8];
            v = (sat_m[d] && s[8]) ? 8'hFF : s[7:0];
          end
          default: begin
            c_m[d] = data > mem_m[d][a];
            v = (sat_m[d] && c_m[d]) ? 8'h00 : mem_m[d][a] - data;
          end
        endcase
        mem_m[d][a] = v;
        z_m[d] = (v == 8'h00);
      end
      e.name = name;
      e.d    = d;
      e.addr = a;
      e.val  = (int'(a) < dep[d]) ? mem_m[d][a] : 8'h00;
      e.c    = c_m[d];
      e.z    = z_m[d];
      sb.push_back(e);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr_a = e.addr;
      #1;
      checks++;
      if (rda[e.d] !== e.val) begin
        errors++;
        $display("FAIL %s dut%0d r%0d data got %h want %h", e.name, e.d, e.addr, rda[e.d], e.val);
      end
      checks++;
      if (carry_v[e.d] !== e.c) begin
        errors++;
        $display("FAIL %s dut%0d carry got %b want %b", e.name, e.d, carry_v[e.d], e.c);
      end
      checks++;
      if (zero_v[e.d] !== e.z) begin
        errors++;
        $display("FAIL %s dut%0d zero got %b want %b", e.name, e.d, zero_v[e.d], e.z);
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] data,
                       input string name, input logic [2:0] mask);
    cmd_valid_v = mask;
    cmd_op      = op;
    cmd_addr    = addr;
    cmd_data    = data;
    model_cmd(op, addr, data, name, mask);
    @(posedge clk);
    #1;
    cmd_valid_v = 3'b000;
    check_sb();
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (d < 2 && a > 3) continue;
        checks++;
        if (rda[d] !== 8'h00) begin
          errors++;
          $display("FAIL %s dut%0d r%0d got %h want 00", name, d, a, rda[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++)
      issue(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 8'($urandom), "rand", 3'b111);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset(3'b111);
    checks++;
    if (ready_v !== 3'b111 || busy_v !== 3'b000) begin
      errors++;
      $display("FAIL reset ready/busy got %b/%b want 111/000", ready_v, busy_v);
    end
    checks++;
    if (zero_v !== 3'b111 || carry_v !== 3'b000) begin
      errors++;
      $display("FAIL reset zero/carry got %b/%b want 111/000", zero_v, carry_v);
    end
    check_all_zero("reset");
  endtask

  task automatic test_wrap();
    issue(2'b01, 3'd1, 8'hF0, "load_f0", 3'b111);
    issue(2'b10, 3'd1, 8'h20, "add_wrap", 3'b111);
    issue(2'b11, 3'd1, 8'h10, "sub_zero", 3'b111);
  endtask

  task automatic test_saturate();
    issue(2'b01, 3'd2, 8'h05, "load_05", 3'b111);
    issue(2'b11, 3'd2, 8'h09, "sub_borrow", 3'b111);
    issue(2'b01, 3'd2, 8'hFE, "load_fe", 3'b111);
    issue(2'b10, 3'd2, 8'h05, "add_carry", 3'b111);
  endtask

  task automatic test_no_bypass();
    issue(2'b01, 3'd0, 8'h3C, "load_r0", 3'b111);
    issue(2'b01, 3'd3, 8'h11, "load_r3_old", 3'b111);
    rd_addr_a   = 3'd3;
    rd_addr_b   = 3'd0;
    cmd_valid_v = 3'b001;
    cmd_op      = 2'b01;
    cmd_addr    = 3'd3;
    cmd_data    = 8'hAA;
    #1;
    checks++;
    if (rda[0] !== 8'h11) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h want 11", rda[0]);
    end
    model_cmd(2'b01, 3'd3, 8'hAA, "load_aa", 3'b001);
    @(posedge clk);
    #1;
    cmd_valid_v = 3'b000;
    checks++;
    if (rda[0] !== 8'hAA) begin
      errors++;
      $display("FAIL bypass_next_cycle got %h want aa", rda[0]);
    end
    checks++;
    if (rdb[0] !== 8'h3C) begin
      errors++;
      $display("FAIL port_b_r0 got %h want 3c", rdb[0]);
    end
    check_sb();
  endtask

  task automatic test_clear();
    logic [7:0] pre [4];
    for (int a = 0; a < 4; a++) begin
      pre[a] = 8'(8'h41 + a);
      issue(2'b01, 3'(a), pre[a], "preload", 3'b011);
    end
    issue(2'b10, 3'd0, 8'hF0, "preload_carry", 3'b011);
    pre[0] = 8'h31;
    cmd_valid_v = 3'b011;
    cmd_op      = 2'b01;
    cmd_addr    = 3'd1;
    cmd_data    = 8'h5A;
    clr_req     = 1'b1;
    #1;
    checks++;
    if (ready_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority ready got %b want 0", ready_v[0]);
    end
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy_v[0] !== 1'b1 || ready_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL sweep_cycle%0d busy/ready got %b/%b want 1/0", k, busy_v[0], ready_v[0]);
      end
      for (int j = 0; j < 4; j++) begin
        rd_addr_a = 3'(j);
        #1;
        checks++;
        if (rda[0] !== ((j < k) ? 8'h00 : pre[j])) begin
          errors++;
          $display("FAIL sweep_cycle%0d r%0d got %h want %h", k, j, rda[0],
                   (j < k) ? 8'h00 : pre[j]);
        end
      end
      clr_req = (k == 1);
      @(posedge clk);
      #1;
    end
    clr_req = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL sweep_exit busy/ready got %b/%b want 0/1", busy_v[0], ready_v[0]);
    end
    checks++;
    if (zero_v[1:0] !== 2'b11 || carry_v[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL sweep_exit zero/carry got %b/%b want 11/00", zero_v[1:0], carry_v[1:0]);
    end
    for (int j = 0; j < 4; j++) begin
      rd_addr_a = 3'(j);
      #1;
      checks++;
      if (rda[0] !== 8'h00) begin
        errors++;
        $display("FAIL sweep_exit r%0d got %h want 00", j, rda[0]);
      end
    end
    model_reset(3'b011);
    model_cmd(2'b01, 3'd1, 8'h5A, "held_cmd", 3'b011);
    @(posedge clk);
    #1;
    cmd_valid_v = 3'b000;
    check_sb();
  endtask

  task automatic test_reset_mid_sweep();
    issue(2'b01, 3'd2, 8'h66, "pre_r2", 3'b011);
    issue(2'b01, 3'd3, 8'h77, "pre_r3", 3'b011);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL midsweep_busy got %b want 1", busy_v[0]);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset(3'b111);
    checks++;
    if (busy_v !== 3'b000 || ready_v !== 3'b111) begin
      errors++;
      $display("FAIL midsweep_reset busy/ready got %b/%b want 000/111", busy_v, ready_v);
    end
    check_all_zero("midsweep_reset");
  endtask

  task automatic test_depth5();
    issue(2'b01, 3'd4, 8'h99, "d5_load4", 3'b111);
    issue(2'b10, 3'd4, 8'h80, "d5_add4", 3'b111);
    issue(2'b01, 3'd6, 8'h00, "d5_oob_write", 3'b111);
    for (int a = 5; a < 8; a++) begin
      rd_addr_b = 3'(a);
      #1;
      checks++;
      if (rdb[2] !== 8'h00) begin
        errors++;
        $display("FAIL d5_oob_read r%0d got %h want 00", a, rdb[2]);
      end
    end
    rd_addr_b = 3'd4;
    #1;
    checks++;
    if (rdb[2] !== 8'h19) begin
      errors++;
      $display("FAIL d5_r4_kept got %h want 19", rdb[2]);
    end
  endtask

  initial begin
    rst         = 1'b0;
    cmd_valid_v = 3'b000;
    cmd_op      = 2'b00;
    cmd_addr    = 3'd0;
    cmd_data    = 8'h00;
    clr_req     = 1'b0;
    clr_req5    = 1'b0;
    rd_addr_a   = 3'd0;
    rd_addr_b   = 3'd0;
    model_reset(3'b111);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    test_reset();
    test_wrap();
    test_saturate();
    test_no_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_depth5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
